// File: rtl/muldiv_execute_unit_if.sv
// Handshake bundle between the E stage and the iterative RV32M unit.
// Master drives the instruction side, slave returns stall/result.
interface muldiv_execute_unit_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic [2:0]       MulDivOpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             FlushE;
    logic             BusyE;
    logic             DoneE;
    logic [WIDTH-1:0] ResultE;

    modport master (
        output StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
        input  BusyE, DoneE, ResultE
    );

    modport slave (
        input  StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
        output BusyE, DoneE, ResultE
    );
endinterface

// File: rtl/muldiv_execute_unit.sv
// Iterative RV32M multiply/divide unit for the E stage (shift-add / restoring).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier instead of shift-add.
module muldiv_execute_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input logic                clk,
    input logic                rst,
    muldiv_execute_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               b_sgn;
    logic               neg_q;
    logic               neg_r;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH-1:0] a, b, abs_a, abs_b;
    logic [2:0]       opin;
    logic             is_mul, a_sgn_in, b_sgn_in;
    logic             div_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic             last;

    assign a        = bus.SrcAE;
    assign b        = bus.SrcBE;
    assign opin     = bus.MulDivOpE;
    assign is_mul   = ~opin[2];
    assign a_sgn_in = (opin[1:0] == 2'b01) | (opin[1:0] == 2'b10);
    assign b_sgn_in = (opin[1:0] == 2'b01);
    assign div_sgn  = ~opin[0];
    assign a_neg    = div_sgn & a[WIDTH-1];
    assign b_neg    = div_sgn & b[WIDTH-1];
    assign abs_a    = a_neg ? -a : a;
    assign abs_b    = b_neg ? -b : b;
    assign div_zero = opin[2] & (b == '0);
    assign div_ovf  = opin[2] & div_sgn & (&b)
                    & (a == {1'b1, {(WIDTH-1){1'b0}}});
    assign last     = (cnt == CNT_W'(WIDTH-1));

    assign bus.BusyE   = ~rst & bus.StartE & (state != DONE) & ~bus.FlushE;
    assign bus.DoneE   = done_q;
    assign bus.ResultE = result_q;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*WIDTH+1:0] fast_prod;
    logic [WIDTH-1:0]          fast_res;

    assign fast_prod = $signed({a_sgn_in & a[WIDTH-1], a})
                     * $signed({b_sgn_in & b[WIDTH-1], b});
    assign fast_res  = (opin[1:0] == 2'b00) ? fast_prod[WIDTH-1:0]
                                            : fast_prod[2*WIDTH-1:WIDTH];
`else
    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{a_sgn_in & a[WIDTH-1]}}, a};
`endif

    // Signed multiplier: top bit carries weight -2^(WIDTH-1), so subtract it.
    logic [2*WIDTH-1:0] mul_add, mul_nx;
    logic [WIDTH-1:0]   mul_res;

    assign mul_add = mplier[0] ? mcand : '0;
    assign mul_nx  = (last & b_sgn) ? acc - mul_add : acc + mul_add;
    assign mul_res = (op[1:0] == 2'b00) ? mul_nx[WIDTH-1:0]
                                        : mul_nx[2*WIDTH-1:WIDTH];

    // Restoring divide: acc holds {remainder, shifting dividend/quotient}.
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix, div_res;

    assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = shifted - {1'b0, mplier};
    assign rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nx  = {acc[WIDTH-2:0], ~diff[WIDTH]};
    assign q_fix   = neg_q ? -quo_nx : quo_nx;
    assign r_fix   = neg_r ? -rem_nx : rem_nx;
    assign div_res = op[1] ? r_fix : q_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            b_sgn    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.FlushE) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: if (bus.StartE) begin
                        cnt <= '0;
                        op  <= opin;
                        unique case (1'b1)
                            is_mul: begin
`ifdef MULDIV_FAST_MUL_EN
                                result_q <= fast_res;
                                done_q   <= 1'b1;
                                state    <= DONE;
`else
                                acc    <= '0;
                                mcand  <= a_ext;
                                mplier <= b;
                                b_sgn  <= b_sgn_in;
                                state  <= MUL;
`endif
                            end
                            div_zero: begin
                                result_q <= opin[1] ? a : '1;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end
                            div_ovf: begin
                                result_q <= opin[1] ? '0 : a;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end
                            default: begin
                                acc    <= {{WIDTH{1'b0}}, abs_a};
                                mplier <= abs_b;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                state  <= DIV;
                            end
                        endcase
                    end
                    MUL: begin
                        acc    <= mul_nx;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (last) begin
                            result_q <= mul_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DIV: begin
                        acc <= {rem_nx, quo_nx};
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            result_q <= div_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: state <= IDLE;
                endcase
            end
        end
    end
endmodule
